// File: rtl/fmm_reduce_mul_arbiter_if.sv
// Request/multiplier/result bundle between the fmm_reduce lanes, the shared
// multiplier and the round-robin arbiter (slave = arbiter side).
interface fmm_reduce_mul_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [DATA_W-1:0]         mul_din0;
    logic [DATA_W-1:0]         mul_din1;
    logic [DATA_W-1:0]         mul_dout;
    logic                      res_valid;
    logic                      res_ready;
    logic [DATA_W-1:0]         res_data;
    logic [ID_W-1:0]           res_id;

    modport slave (
        input  req_valid, req_a, req_b, mul_dout, res_ready,
        output req_ready, mul_din0, mul_din1, res_valid, res_data, res_id
    );

    modport master (
        output req_valid, req_a, req_b, mul_dout, res_ready,
        input  req_ready, mul_din0, mul_din1, res_valid, res_data, res_id
    );
endinterface

// File: rtl/fmm_reduce_mul_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier across NUM_REQ requesters,
// with a one-entry tagged result slot. FMM_MUL_ARB_STATS_EN adds grant/stall counters.
module fmm_reduce_mul_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_W    = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
`ifdef FMM_MUL_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0] grant_cnt,
    output logic [15:0]           stall_cnt,
`endif
    fmm_reduce_mul_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} slot_e;

    slot_e             slot_q, slot_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;

    logic              slot_free;
    logic              accept;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   cand;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [DATA_W-1:0] din0_c, din1_c;

`ifdef FMM_MUL_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] grant_cnt_q, grant_cnt_d;
    logic [15:0]           stall_cnt_q, stall_cnt_d;
`endif

    always_comb begin
        slot_free = (slot_q == EMPTY) || bus.res_ready;
        accept    = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        // Search starts one past the last winner; reset blocks any grant.
        if (slot_free && !ap_rst) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = ID_W'((32'(last_grant_q) + k) % NUM_REQ);
                if (!accept && bus.req_valid[cand]) begin
                    accept  = 1'b1;
                    gnt_idx = cand;
                end
            end
        end

        req_ready_c = '0;
        din0_c      = '0;
        din1_c      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (accept && gnt_idx == ID_W'(i)) begin
                req_ready_c[i] = 1'b1;
                din0_c         = bus.req_a[i*DATA_W +: DATA_W];
                din1_c         = bus.req_b[i*DATA_W +: DATA_W];
            end
        end

        slot_d       = slot_q;
        last_grant_d = last_grant_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        if (accept) begin
            slot_d       = FULL;
            last_grant_d = gnt_idx;
            res_data_d   = bus.mul_dout;
            res_id_d     = gnt_idx;
        end else if (slot_q == FULL && bus.res_ready) begin
            slot_d = EMPTY;
        end

`ifdef FMM_MUL_ARB_STATS_EN
        grant_cnt_d = grant_cnt_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (accept && gnt_idx == ID_W'(i) && grant_cnt_q[i*16 +: 16] != 16'hFFFF)
                grant_cnt_d[i*16 +: 16] = grant_cnt_q[i*16 +: 16] + 16'd1;
        end
        stall_cnt_d = stall_cnt_q;
        if (slot_q == FULL && !bus.res_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
`endif
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            slot_q       <= EMPTY;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            res_data_q   <= '0;
            res_id_q     <= '0;
`ifdef FMM_MUL_ARB_STATS_EN
            grant_cnt_q  <= '0;
            stall_cnt_q  <= '0;
`endif
        end else begin
            slot_q       <= slot_d;
            last_grant_q <= last_grant_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
`ifdef FMM_MUL_ARB_STATS_EN
            grant_cnt_q  <= grant_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.mul_din0  = din0_c;
    assign bus.mul_din1  = din1_c;
    assign bus.res_valid = (slot_q == FULL);
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;

`ifdef FMM_MUL_ARB_STATS_EN
    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fmm_reduce_mul_arbiter.sv
// Directed bench for fmm_reduce_mul_arbiter (NUM_REQ=4, DATA_W=32) with a
// behavioural shared multiplier on the mul_din/mul_dout port.
module tb_fmm_reduce_mul_arbiter;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    fmm_reduce_mul_arbiter_if #(.NUM_REQ(4), .DATA_W(32), .ID_W(2)) bus ();

`ifdef FMM_MUL_ARB_STATS_EN
    logic [63:0] grant_cnt;
    logic [15:0] stall_cnt;
`endif

    fmm_reduce_mul_arbiter #(.NUM_REQ(4), .DATA_W(32), .ID_W(2)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
`ifdef FMM_MUL_ARB_STATS_EN
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus)
    );

    assign bus.mul_dout = 32'($signed(bus.mul_din0) * $signed(bus.mul_din1));

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    initial begin
        int g;
        bus.req_valid = 4'b1111;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 32'(i + 1), 32'(10 * (i + 1)));

        // Reset: requests held high must not be granted
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_din0", 64'(bus.mul_din0), 64'h0);
        tick();
        tick();
        chk("rst_valid", 64'(bus.res_valid), 64'h0);
        chk("rst_data", 64'(bus.res_data), 64'h0);
        chk("rst_id", 64'(bus.res_id), 64'h0);
        chk("rst_ready2", 64'(bus.req_ready), 64'h0);

        // Single request from requester 2: 7 * -3
        ap_rst        = 1'b0;
        bus.req_valid = 4'b0100;
        bus.res_ready = 1'b1;
        set_op(2, 32'd7, 32'hFFFF_FFFD);
        #1;
        chk("single_ready", 64'(bus.req_ready), 64'h4);
        chk("single_din0", 64'(bus.mul_din0), 64'h7);
        chk("single_din1", 64'(bus.mul_din1), 64'hFFFF_FFFD);
        tick();
        chk("single_valid", 64'(bus.res_valid), 64'h1);
        chk("single_data", 64'(bus.res_data), 64'hFFFF_FFEB);
        chk("single_id", 64'(bus.res_id), 64'h2);
        bus.req_valid = 4'b0000;
        #1;
        chk("idle_ready", 64'(bus.req_ready), 64'h0);
        chk("idle_din1", 64'(bus.mul_din1), 64'h0);
        tick();
        chk("drain_valid", 64'(bus.res_valid), 64'h0);

        // Round robin: last winner was 2, so order is 3,0,1,2,3,0,1,2
        set_op(2, 32'd3, 32'd30);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            g = (3 + k) % 4;
            #1;
            chk("rr_ready", 64'(bus.req_ready), 64'(1 << g));
            tick();
            chk("rr_valid", 64'(bus.res_valid), 64'h1);
            chk("rr_id", 64'(bus.res_id), 64'(g));
            chk("rr_data", 64'(bus.res_data), 64'(10 * (g + 1) * (g + 1)));
        end

        // Backpressure: slot holds requester 2's result (3*30)
        bus.res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", 64'(bus.req_ready), 64'h0);
            tick();
            chk("bp_valid", 64'(bus.res_valid), 64'h1);
            chk("bp_data", 64'(bus.res_data), 64'd90);
            chk("bp_id", 64'(bus.res_id), 64'h2);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus.req_ready), 64'h8);
        tick();
        chk("bp_reload_valid", 64'(bus.res_valid), 64'h1);
        chk("bp_reload_id", 64'(bus.res_id), 64'h3);
        chk("bp_reload_data", 64'(bus.res_data), 64'd160);

        // Wrap arithmetic on requester 0
        bus.req_valid = 4'b0001;
        set_op(0, 32'h7FFF_FFFF, 32'd2);
        #1;
        chk("wrap1_ready", 64'(bus.req_ready), 64'h1);
        tick();
        chk("wrap1_data", 64'(bus.res_data), 64'hFFFF_FFFE);
        chk("wrap1_id", 64'(bus.res_id), 64'h0);
        set_op(0, 32'h8000_0000, 32'hFFFF_FFFF);
        #1;
        chk("wrap2_ready", 64'(bus.req_ready), 64'h1);
        tick();
        chk("wrap2_data", 64'(bus.res_data), 64'h8000_0000);
        chk("wrap2_valid", 64'(bus.res_valid), 64'h1);

        // Reset while FULL and stalled
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b0;
        tick();
        chk("mid_full", 64'(bus.res_valid), 64'h1);
        ap_rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(bus.req_ready), 64'h0);
        tick();
        chk("mid_rst_valid", 64'(bus.res_valid), 64'h0);
        chk("mid_rst_data", 64'(bus.res_data), 64'h0);
        ap_rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus.req_ready), 64'h1);
        tick();
        chk("post_rst_id", 64'(bus.res_id), 64'h0);
        chk("post_rst_data", 64'(bus.res_data), 64'h8000_0000);

`ifdef FMM_MUL_ARB_STATS_EN
        ap_rst = 1'b1;
        tick();
        ap_rst        = 1'b0;
        bus.req_valid = 4'b0010;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        bus.req_valid = 4'b0000;
        bus.res_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("stat_grant1", 64'(grant_cnt[31:16]), 64'd10);
        chk("stat_grant0", 64'(grant_cnt[15:0]), 64'd0);
        chk("stat_stall", 64'(stall_cnt), 64'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
